// File: rtl/uart_stream_pkg.sv
// Shared definitions for the UART word streamer: FSM state encoding,
// streaming mode and the default host command bytes.
package uart_stream_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_REQ   = 3'd1,
    ST_LOAD  = 3'd2,
    ST_SEND  = 3'd3,
    ST_WAIT  = 3'd4,
    ST_CKSUM = 3'd5
  } state_t;

  typedef enum logic {
    MODE_RUN  = 1'b0,
    MODE_STEP = 1'b1
  } mode_t;

  localparam logic [7:0] CMD_RUN_DEF  = 8'd82;  // 'R'
  localparam logic [7:0] CMD_STOP_DEF = 8'd83;  // 'S'
  localparam logic [7:0] CMD_STEP_DEF = 8'd78;  // 'N'
  localparam logic [7:0] CMD_CLR_DEF  = 8'd67;  // 'C'

endpackage

// File: rtl/uart_rx.sv
// 8N1 UART receiver: double-synchronised input, mid-bit sampling,
// one-cycle o_rx_dv pulse when a byte with a valid stop bit arrives.
module uart_rx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_rxd,
  output logic       o_rx_dv,
  output logic [7:0] o_rx_byte
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] HALF = CW'((CLKS_PER_BIT - 1) / 2);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    sync_q;
  logic [1:0]    phase_q;   // 0 idle, 1 start, 2 data, 3 stop
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    byte_q;
  logic          dv_q;
  logic          rxd;

  assign rxd       = sync_q[1];
  assign o_rx_dv   = dv_q;
  assign o_rx_byte = byte_q;

  // Bit-timing state machine sampling each bit at its centre.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sync_q  <= 2'b11;
      phase_q <= 2'd0;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      byte_q  <= 8'd0;
      dv_q    <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], i_rxd};
      dv_q   <= 1'b0;
      case (phase_q)
        2'd0: if (!rxd) begin
          phase_q <= 2'd1;
          cnt_q   <= '0;
        end
        2'd1: if (cnt_q == HALF) begin
          cnt_q   <= '0;
          bit_q   <= 3'd0;
          phase_q <= rxd ? 2'd0 : 2'd2;  // glitch: back to idle
        end else cnt_q <= cnt_q + CW'(1);
        2'd2: if (cnt_q == FULL) begin
          cnt_q         <= '0;
          byte_q[bit_q] <= rxd;
          if (bit_q == 3'd7) phase_q <= 2'd3;
          else               bit_q   <= bit_q + 3'd1;
        end else cnt_q <= cnt_q + CW'(1);
        default: if (cnt_q == FULL) begin
          phase_q <= 2'd0;
          dv_q    <= rxd;
        end else cnt_q <= cnt_q + CW'(1);
      endcase
    end
  end
endmodule

// File: rtl/uart_stream_ser.sv
// Word serialiser: holds the current word, presents the next byte in the
// configured byte order, counts bytes and accumulates the XOR checksum.
module uart_stream_ser #(
  parameter int unsigned WORD_BYTES = 8,
  parameter bit          MSB_FIRST  = 1'b1
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_load,
  input  logic [8*WORD_BYTES-1:0] i_data,
  input  logic                    i_shift,
  input  logic                    i_acc,
  input  logic                    i_clr_cks,
  output logic [7:0]              o_byte,
  output logic [7:0]              o_cks,
  output logic                    o_last
);
  localparam int DW    = 8 * WORD_BYTES;
  localparam int CNT_W = $clog2(WORD_BYTES) + 1;

  logic [DW-1:0]    sh_q;
  logic [DW-1:0]    sh_shift;
  logic [CNT_W-1:0] cnt_q;
  logic [7:0]       cks_q;

  // The send end of the register is the top byte for MSB-first, else the bottom.
  generate
    if (MSB_FIRST) begin : g_msb
      assign o_byte   = sh_q[DW-1 -: 8];
      assign sh_shift = sh_q << 8;
    end else begin : g_lsb
      assign o_byte   = sh_q[7:0];
      assign sh_shift = sh_q >> 8;
    end
  endgenerate

  assign o_cks  = cks_q;
  assign o_last = (cnt_q == CNT_W'(WORD_BYTES - 1));

  // Shift register and byte counter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      sh_q  <= '0;
      cnt_q <= '0;
    end else if (i_load) begin
      sh_q  <= i_data;
      cnt_q <= '0;
    end else if (i_shift) begin
      sh_q  <= sh_shift;
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // XOR checksum over every byte handed to the transmitter.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)       cks_q <= 8'd0;
    else if (i_clr_cks) cks_q <= 8'd0;
    else if (i_acc)     cks_q <= cks_q ^ o_byte;
  end
endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter. o_tx_done pulses in the first idle cycle after the
// stop bit, so a new byte may be issued on the very next cycle.
module uart_tx #(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tx_dv,
  input  logic [7:0] i_tx_byte,
  output logic       o_txd,
  output logic       o_tx_done
);
  localparam int CW = $clog2(CLKS_PER_BIT) + 1;
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);

  logic [1:0]    phase_q;   // 0 idle, 1 start, 2 data, 3 stop
  logic [CW-1:0] cnt_q;
  logic [2:0]    bit_q;
  logic [7:0]    sh_q;
  logic          txd_q;
  logic          done_q;

  assign o_txd     = txd_q;
  assign o_tx_done = done_q;

  // Frame generator: start bit, eight data bits LSB first, stop bit.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      phase_q <= 2'd0;
      cnt_q   <= '0;
      bit_q   <= 3'd0;
      sh_q    <= 8'd0;
      txd_q   <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (phase_q)
        2'd0: begin
          txd_q <= 1'b1;
          if (i_tx_dv) begin
            sh_q    <= i_tx_byte;
            txd_q   <= 1'b0;
            cnt_q   <= '0;
            phase_q <= 2'd1;
          end
        end
        2'd1: if (cnt_q == FULL) begin
          cnt_q   <= '0;
          bit_q   <= 3'd0;
          txd_q   <= sh_q[0];
          sh_q    <= {1'b0, sh_q[7:1]};
          phase_q <= 2'd2;
        end else cnt_q <= cnt_q + CW'(1);
        2'd2: if (cnt_q == FULL) begin
          cnt_q <= '0;
          if (bit_q == 3'd7) begin
            txd_q   <= 1'b1;
            phase_q <= 2'd3;
          end else begin
            bit_q <= bit_q + 3'd1;
            txd_q <= sh_q[0];
            sh_q  <= {1'b0, sh_q[7:1]};
          end
        end else cnt_q <= cnt_q + CW'(1);
        default: if (cnt_q == FULL) begin
          phase_q <= 2'd0;
          done_q  <= 1'b1;
        end else cnt_q <= cnt_q + CW'(1);
      endcase
    end
  end
endmodule

// File: rtl/uart_stream_tx.sv
// Host-commanded streamer: pulls words from the FFT controller over
// ready/valid and sends them as bytes on UART TX, with optional checksum.
module uart_stream_tx import uart_stream_pkg::*; #(
  parameter int unsigned WORD_BYTES   = 8,
  parameter int unsigned DATA_LENGTH  = 256,
  parameter int unsigned CLKS_PER_BIT = 434,
  parameter bit          MSB_FIRST    = 1'b1,
  parameter bit          CHECKSUM_EN  = 1'b1,
  parameter logic [7:0]  CMD_RUN      = CMD_RUN_DEF,
  parameter logic [7:0]  CMD_STOP     = CMD_STOP_DEF,
  parameter logic [7:0]  CMD_STEP     = CMD_STEP_DEF,
  parameter logic [7:0]  CMD_CLR      = CMD_CLR_DEF
) (
  input  logic                           i_clk,
  input  logic                           i_rst_n,
  input  logic                           i_rxd,
  output logic                           o_txd,
  input  logic [8*WORD_BYTES-1:0]        i_fft_data,
  input  logic                           i_tx_valid,
  output logic                           o_tx_ready,
  output logic                           o_busy,
  output logic [$clog2(DATA_LENGTH)-1:0] o_word_idx,
  output logic                           o_frame_done
);
  localparam int IDX_W = $clog2(DATA_LENGTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_LENGTH - 1);

  logic [1:0]       rst_sync_q;
  logic             rst_n_int;
  state_t           state_q, state_d;
  mode_t            mode_q, mode_d;
  logic             abort_q, abort_d;
  logic             cks_sent_q, cks_sent_d;
  logic             fd_q, fd_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             rx_dv, tx_dv, tx_done, stop_cmd;
  logic [7:0]       rx_byte, tx_byte, ser_byte, ser_cks;
  logic             ser_load, ser_shift, ser_acc, ser_clr, ser_last;

  // Reset asserts immediately but is released on a clock edge.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n_int = rst_sync_q[1];

  uart_rx #(.CLKS_PER_BIT(int'(CLKS_PER_BIT))) u_rx (
    .i_clk(i_clk), .i_rst_n(rst_n_int), .i_rxd(i_rxd),
    .o_rx_dv(rx_dv), .o_rx_byte(rx_byte)
  );

  uart_tx #(.CLKS_PER_BIT(int'(CLKS_PER_BIT))) u_tx (
    .i_clk(i_clk), .i_rst_n(rst_n_int), .i_tx_dv(tx_dv), .i_tx_byte(tx_byte),
    .o_txd(o_txd), .o_tx_done(tx_done)
  );

  uart_stream_ser #(.WORD_BYTES(WORD_BYTES), .MSB_FIRST(MSB_FIRST)) u_ser (
    .i_clk(i_clk), .i_rst_n(rst_n_int), .i_load(ser_load), .i_data(i_fft_data),
    .i_shift(ser_shift), .i_acc(ser_acc), .i_clr_cks(ser_clr),
    .o_byte(ser_byte), .o_cks(ser_cks), .o_last(ser_last)
  );

  assign stop_cmd = rx_dv && (rx_byte == CMD_STOP);

  // State register and FSM-owned bookkeeping.
  always_ff @(posedge i_clk or negedge rst_n_int) begin
    if (!rst_n_int) begin
      state_q    <= ST_IDLE;
      mode_q     <= MODE_RUN;
      abort_q    <= 1'b0;
      cks_sent_q <= 1'b0;
      fd_q       <= 1'b0;
      idx_q      <= '0;
    end else begin
      state_q    <= state_d;
      mode_q     <= mode_d;
      abort_q    <= abort_d;
      cks_sent_q <= cks_sent_d;
      fd_q       <= fd_d;
      idx_q      <= idx_d;
    end
  end

  // Next-state logic: command decode, handshake, byte sequencing, abort.
  always_comb begin
    state_d    = state_q;
    mode_d     = mode_q;
    abort_d    = abort_q;
    cks_sent_d = cks_sent_q;
    fd_d       = 1'b0;
    idx_d      = idx_q;
    ser_load   = 1'b0;
    ser_shift  = 1'b0;
    ser_clr    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        abort_d    = 1'b0;
        cks_sent_d = 1'b0;
        if (rx_dv) begin
          if (rx_byte == CMD_RUN) begin
            mode_d  = MODE_RUN;
            state_d = ST_REQ;
          end else if (rx_byte == CMD_STEP) begin
            mode_d  = MODE_STEP;
            state_d = ST_REQ;
          end else if (rx_byte == CMD_CLR) begin
            idx_d   = '0;
            ser_clr = 1'b1;
          end
        end
      end
      ST_REQ: begin
        if (stop_cmd) begin
          state_d = ST_IDLE;
        end else if (i_tx_valid) begin
          ser_load = 1'b1;
          state_d  = ST_SEND;
        end
      end
      ST_LOAD: state_d = ST_SEND;
      ST_SEND: begin
        if (stop_cmd) abort_d = 1'b1;
        state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (stop_cmd) abort_d = 1'b1;
        if (tx_done) begin
          ser_shift = 1'b1;
          if (abort_q || stop_cmd) begin
            state_d = ST_IDLE;
            idx_d   = '0;
            ser_clr = 1'b1;
            abort_d = 1'b0;
          end else if (!ser_last) begin
            state_d = ST_SEND;
          end else if (idx_q == LAST_IDX) begin
            idx_d = '0;
            if (CHECKSUM_EN) begin
              state_d    = ST_CKSUM;
              cks_sent_d = 1'b0;
            end else begin
              fd_d    = 1'b1;
              state_d = ST_IDLE;
            end
          end else begin
            idx_d   = idx_q + IDX_W'(1);
            state_d = (mode_q == MODE_RUN) ? ST_REQ : ST_IDLE;
          end
        end
      end
      ST_CKSUM: begin
        cks_sent_d = 1'b1;
        if (tx_done) begin
          ser_clr    = 1'b1;
          fd_d       = 1'b1;
          abort_d    = 1'b0;
          cks_sent_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Outputs decoded from the current state.
  always_comb begin
    o_tx_ready   = (state_q == ST_REQ);
    o_busy       = (state_q != ST_IDLE);
    ser_acc      = (state_q == ST_SEND);
    tx_dv        = (state_q == ST_SEND) || ((state_q == ST_CKSUM) && !cks_sent_q);
    tx_byte      = (state_q == ST_CKSUM) ? ser_cks : ser_byte;
    o_word_idx   = idx_q;
    o_frame_done = fd_q;
  end
endmodule

// File: tb/tb_uart_stream_tx.sv
// Bench for uart_stream_tx: two instances (MSB-first with checksum, and
// LSB-first without), UART command driver, TX byte monitors and scoreboard.
module tb_uart_stream_tx;
  localparam int CPB = 8;

  logic clk = 1'b0;
  logic rst_n;
  logic a_rxd, a_txd, a_valid, a_ready, a_busy, a_fd;
  logic b_rxd, b_txd, b_valid, b_ready, b_busy, b_fd;
  logic [31:0] a_data, b_data;
  logic [1:0]  a_idx, b_idx;

  int tests = 0;
  int failed = 0;
  bit mon_en = 1'b1;
  logic [7:0] q_a[$];
  logic [7:0] q_b[$];
  int fd_cnt[2] = '{0, 0};
  int m_fd[2] = '{0, 0};
  int m_idx[2] = '{0, 0};
  logic [7:0] m_cks[2] = '{8'h00, 8'h00};

  typedef struct {
    int          sel;
    logic [31:0] word;
    logic [1:0]  exp_idx;
    int          exp_fd;
  } vec_t;
  vec_t tbl[6];

  always #5 clk = ~clk;

  uart_stream_tx #(.WORD_BYTES(4), .DATA_LENGTH(4), .CLKS_PER_BIT(CPB),
                   .MSB_FIRST(1'b1), .CHECKSUM_EN(1'b1)) dut_a (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(a_rxd), .o_txd(a_txd),
    .i_fft_data(a_data), .i_tx_valid(a_valid), .o_tx_ready(a_ready),
    .o_busy(a_busy), .o_word_idx(a_idx), .o_frame_done(a_fd)
  );

  uart_stream_tx #(.WORD_BYTES(4), .DATA_LENGTH(4), .CLKS_PER_BIT(CPB),
                   .MSB_FIRST(1'b0), .CHECKSUM_EN(1'b0)) dut_b (
    .i_clk(clk), .i_rst_n(rst_n), .i_rxd(b_rxd), .o_txd(b_txd),
    .i_fft_data(b_data), .i_tx_valid(b_valid), .o_tx_ready(b_ready),
    .o_busy(b_busy), .o_word_idx(b_idx), .o_frame_done(b_fd)
  );

  always @(posedge clk) begin
    if (a_fd) fd_cnt[0] <= fd_cnt[0] + 1;
    if (b_fd) fd_cnt[1] <= fd_cnt[1] + 1;
  end

  function automatic logic get_txd(input int s);   return (s == 0) ? a_txd : b_txd;     endfunction
  function automatic logic get_ready(input int s); return (s == 0) ? a_ready : b_ready; endfunction
  function automatic logic get_busy(input int s);  return (s == 0) ? a_busy : b_busy;   endfunction
  function automatic logic [1:0] get_idx(input int s); return (s == 0) ? a_idx : b_idx; endfunction
  function automatic int qsize(input int s); return (s == 0) ? q_a.size() : q_b.size(); endfunction

  function automatic void push(input int s, input logic [7:0] v);
    if (s == 0) q_a.push_back(v);
    else        q_b.push_back(v);
  endfunction

  function automatic logic [7:0] qpop(input int s);
    if (s == 0) return q_a.pop_front();
    return q_b.pop_front();
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Capture each byte on a TX line and compare it against the expected queue.
  task automatic tx_monitor(input int s);
    logic [7:0] b;
    logic [7:0] e;
    logic       stp;
    wait (rst_n === 1'b1);
    forever begin
      @(negedge clk);
      if (get_txd(s) == 1'b0) begin
        repeat (CPB / 2) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
          repeat (CPB) @(negedge clk);
          b[i] = get_txd(s);
        end
        repeat (CPB) @(negedge clk);
        stp = get_txd(s);
        if (mon_en) begin
          tests++;
          if (qsize(s) == 0) begin
            failed++;
            $display("FAIL tx%0d_unexpected: got byte %02h, no byte expected", s, b);
          end else begin
            e = qpop(s);
            if (b !== e || stp !== 1'b1) begin
              failed++;
              $display("FAIL tx%0d_byte: got %02h stop %0b, expected %02h stop 1", s, b, stp, e);
            end else begin
              $display("[TB] dut%0d tx byte %02h", s, b);
            end
          end
        end
      end
    end
  endtask

  initial tx_monitor(0);
  initial tx_monitor(1);

  task automatic set_rxd(input int s, input logic v);
    if (s == 0) a_rxd = v;
    else        b_rxd = v;
  endtask

  task automatic send_cmd(input int s, input logic [7:0] c);
    logic [9:0] frame;
    frame = {1'b1, c, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_rxd(s, frame[i]);
      repeat (CPB) @(negedge clk);
    end
  endtask

  // Wait for o_tx_ready, hand over one word, and queue its expected bytes.
  task automatic supply(input int s, input logic [31:0] w, input bit do_push);
    int n;
    logic [7:0] b;
    n = 0;
    while (get_ready(s) !== 1'b1 && n < 3000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("ready_wait%0d", s), (n < 3000) ? 32'd1 : 32'd0, 32'd1);
    if (n >= 3000) return;
    if (do_push) begin
      for (int k = 0; k < 4; k++) begin
        b = (s == 0) ? w[31 - 8*k -: 8] : w[8*k +: 8];
        push(s, b);
        m_cks[s] = m_cks[s] ^ b;
      end
      if (m_idx[s] == 3) begin
        if (s == 0) push(0, m_cks[0]);
        m_cks[s] = 8'h00;
        m_idx[s] = 0;
        m_fd[s]++;
      end else begin
        m_idx[s]++;
      end
    end
    if (s == 0) begin a_data = w; a_valid = 1'b1; end
    else        begin b_data = w; b_valid = 1'b1; end
    @(negedge clk);
    a_valid = 1'b0;
    b_valid = 1'b0;
    check($sformatf("ready_drop%0d", s), {31'd0, get_ready(s)}, 32'd0);
  endtask

  task automatic wait_idle(input int s);
    int n;
    n = 0;
    while (get_busy(s) !== 1'b0 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    check($sformatf("idle_wait%0d", s), (n < 5000) ? 32'd1 : 32'd0, 32'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int quiet_bad;
    rst_n = 1'b0;
    a_rxd = 1'b1; b_rxd = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0;
    a_data = '0; b_data = '0;
    tbl[0] = '{0, 32'h11223344, 2'd1, 0};
    tbl[1] = '{0, 32'hDEADBEEF, 2'd2, 0};
    tbl[2] = '{1, 32'hA1B2C3D4, 2'd1, 0};
    tbl[3] = '{1, 32'h55667788, 2'd2, 0};
    tbl[4] = '{1, 32'h99AABBCC, 2'd3, 0};
    tbl[5] = '{1, 32'h0F1E2D3C, 2'd0, 1};

    // Reset values
    repeat (3) @(negedge clk);
    check("rst_txd",   {31'd0, a_txd},   32'd1);
    check("rst_ready", {31'd0, a_ready}, 32'd0);
    check("rst_busy",  {31'd0, a_busy},  32'd0);
    check("rst_idx",   {30'd0, a_idx},   32'd0);
    check("rst_fd",    {31'd0, a_fd},    32'd0);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);

    // Single-word steps on both byte orders
    for (int i = 0; i < 6; i++) begin
      send_cmd(tbl[i].sel, 8'h4E);
      supply(tbl[i].sel, tbl[i].word, 1'b1);
      wait_idle(tbl[i].sel);
      repeat (4) @(negedge clk);
      $display("[TB] step %0d dut%0d word %08h idx %0d", i, tbl[i].sel, tbl[i].word, get_idx(tbl[i].sel));
      check($sformatf("step%0d_idx", i), {30'd0, get_idx(tbl[i].sel)}, {30'd0, tbl[i].exp_idx});
      check($sformatf("step%0d_fd", i), fd_cnt[tbl[i].sel], tbl[i].exp_fd);
      check($sformatf("step%0d_drain", i), qsize(tbl[i].sel), 0);
    end

    // Clear in idle after two steps
    send_cmd(0, 8'h43);
    repeat (4) @(negedge clk);
    check("clr_idx", {30'd0, a_idx}, 32'd0);
    m_idx[0] = 0;
    m_cks[0] = 8'h00;

    // Full frame with 'R' and 'C' injected while busy
    send_cmd(0, 8'h52);
    fork
      begin
        supply(0, 32'h01020304, 1'b1);
        supply(0, 32'h05060708, 1'b1);
        supply(0, 32'h090A0B0C, 1'b1);
        supply(0, 32'h0D0E0F10, 1'b1);
      end
      begin
        repeat (150) @(negedge clk);
        send_cmd(0, 8'h52);
        send_cmd(0, 8'h43);
      end
    join
    wait_idle(0);
    repeat (4) @(negedge clk);
    $display("[TB] run frame done idx %0d frame_done count %0d", a_idx, fd_cnt[0]);
    check("run_idx", {30'd0, a_idx}, 32'd0);
    check("run_fd", fd_cnt[0], m_fd[0]);
    check("run_drain", qsize(0), 0);

    // STOP during the second byte of a word
    send_cmd(0, 8'h52);
    push(0, 8'hAA);
    push(0, 8'hBB);
    supply(0, 32'hAABBCCDD, 1'b0);
    repeat (40) @(negedge clk);
    send_cmd(0, 8'h53);
    wait_idle(0);
    repeat (200) @(negedge clk);
    m_idx[0] = 0;
    m_cks[0] = 8'h00;
    $display("[TB] abort done idx %0d", a_idx);
    check("abort_idx", {30'd0, a_idx}, 32'd0);
    check("abort_ready", {31'd0, a_ready}, 32'd0);
    check("abort_drain", qsize(0), 0);

    // STOP while waiting for a word
    send_cmd(0, 8'h52);
    check("run_ready", {31'd0, a_ready}, 32'd1);
    send_cmd(0, 8'h53);
    $display("[TB] stop in request ready %0b busy %0b", a_ready, a_busy);
    check("reqstop_ready", {31'd0, a_ready}, 32'd0);
    check("reqstop_busy", {31'd0, a_busy}, 32'd0);
    check("reqstop_idx", {30'd0, a_idx}, 32'd0);

    // Reset asserted in the middle of a byte
    send_cmd(0, 8'h52);
    mon_en = 1'b0;
    supply(0, 32'h12345678, 1'b0);
    repeat (30) @(negedge clk);
    #3 rst_n = 1'b0;
    #1;
    $display("[TB] mid-stream reset txd %0b busy %0b", a_txd, a_busy);
    check("arst_txd",   {31'd0, a_txd},   32'd1);
    check("arst_ready", {31'd0, a_ready}, 32'd0);
    check("arst_busy",  {31'd0, a_busy},  32'd0);
    check("arst_idx",   {30'd0, a_idx},   32'd0);
    check("arst_fd",    {31'd0, a_fd},    32'd0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    quiet_bad = 0;
    repeat (200) begin
      @(negedge clk);
      if (!a_txd || !b_txd || a_ready || a_busy) quiet_bad++;
    end
    check("quiet_after_reset", quiet_bad, 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end
endmodule

// File: doc/uart_stream_tx.md
Name: uart_stream_tx

Overview:
- Next-generation host link for the FFT result path. It replaces the fixed 64-bit, 256-word single-word-per-command streamer.
- Receives single-byte commands from the host over UART and pulls words from the FFT controller with a ready/valid handshake. It serialises each word as WORD_BYTES bytes, in either byte order, over UART TX.
- Supports whole-frame streaming, single-word stepping, mid-frame abort and an optional XOR checksum trailer.
- Sits between the FFT controller and the board RXD/TXD pins.

Parameters:
- WORD_BYTES, 8, bytes per data word (data width = 8*WORD_BYTES); legal range 1..16.
- DATA_LENGTH, 256, words per frame; must be ≥2.
- CLKS_PER_BIT, 434, UART bit period in i_clk cycles (50 MHz / 115200).
- MSB_FIRST, 1, 1 = most-significant byte sent first; 0 = least-significant byte first.
- CHECKSUM_EN, 1, 1 = append one XOR checksum byte after the last word of a frame.
- CMD_RUN, 82, command byte 'R': stream from the current index to end of frame.
- CMD_STOP, 83, command byte 'S': abort.
- CMD_STEP, 78, command byte 'N': send exactly one word.
- CMD_CLR, 67, command byte 'C': clear the word index and checksum.

Ports:
- i_clk  in  1  system clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_rxd  in  1  UART serial in.
- o_txd  out  1  UART serial out.
- i_fft_data  in  8*WORD_BYTES  word from the FFT controller.
- i_tx_valid  in  1  i_fft_data is valid.
- o_tx_ready  out  1  block requests a word; level signal, held until handshake.
- o_busy  out  1  high in any state other than IDLE.
- o_word_idx  out  $clog2(DATA_LENGTH)  index of the next word to send.
- o_frame_done  out  1  one-cycle pulse after the last byte of a frame (checksum included).

Behaviour:
- Reset (async assert, sync release): state IDLE, o_tx_ready=0, o_busy=0, o_word_idx=0, o_frame_done=0, checksum=0, TX DV=0. o_txd idles high via the uart_tx sub-module.
- States:
  - IDLE
  - REQ: o_tx_ready=1.
  - LOAD
  - SEND: pulse TX DV with the current byte.
  - WAIT: wait for TX done.
  - CKSUM: send the checksum byte.
- Commands are decoded only on the RX data-valid pulse.
- In IDLE:
  - RUN sets mode=RUN and goes to REQ.
  - STEP sets mode=STEP and goes to REQ.
  - CLR zeroes o_word_idx and the checksum; state stays IDLE.
  - STOP and unknown bytes are ignored.
- While busy:
  - Only STOP is honoured; all other bytes are dropped.
  - STOP sets an abort flag, acted on at the next byte boundary.
  - No byte is ever truncated on the line.
- REQ: on i_tx_valid=1, latch i_fft_data into the shift register and deassert o_tx_ready in the same edge, then go to SEND. No timeout.
- SEND: drive TX DV for exactly one cycle with the current byte. The byte is [top] if MSB_FIRST, else [bottom]. XOR the byte into the checksum, go to WAIT.
- WAIT: on TX done, shift the register by 8 toward the send end and increment the byte counter. Then:
  - abort flag set → IDLE; word index and checksum cleared.
  - bytes remaining → SEND.
  - word complete → increment o_word_idx and apply the end-of-word rules below.
- End-of-word rules:
  - idx was DATA_LENGTH-1: wrap o_word_idx to 0. Go to CKSUM if CHECKSUM_EN, else pulse o_frame_done and go to IDLE.
  - mode=RUN and not last word: go to REQ.
  - mode=STEP: go to IDLE.
- CKSUM: send the checksum byte and wait for TX done. Then clear the checksum, pulse o_frame_done and go to IDLE. STOP during CKSUM still lets the byte finish.
- Latency:
  - RX DV of RUN → o_tx_ready high next cycle.
  - Handshake → TX DV 1 cycle later.
  - Inter-byte gap: 1 cycle after TX done.
- STOP while in REQ: go to IDLE immediately, o_tx_ready drops; no word is consumed.
- A RUN issued from idx k>0 (after STEPs) streams words k..DATA_LENGTH-1. The checksum covers all bytes sent since the last clear or frame end.
- i_tx_valid outside REQ is ignored.

Decomposition:
- Package uart_stream_pkg: state encoding constants and default command byte values.
- Sub-modules: the existing uart_rx and uart_tx are instantiated unchanged.
- One new sub-module, uart_stream_ser: shift register, byte counter, MSB/LSB select and checksum accumulator, controlled by load/shift/clear strobes from the FSM.

Test Plan:
All scenarios use CLKS_PER_BIT=8, WORD_BYTES=4, DATA_LENGTH=4.
- Reset/idle: hold i_rst_n=0 mid-stream → all outputs at reset values asynchronously and o_txd=1. After release, no TX activity until a command arrives.
- STEP with MSB_FIRST=1: send 'N', then supply 0x11223344 on valid → TX bytes 11,22,33,44; o_word_idx=1; return to IDLE.
- RUN full frame: words 0x01020304, 0x05060708, 0x090A0B0C, 0x0D0E0F10 → 16 bytes, then checksum byte 0x10. o_frame_done pulses once; o_word_idx wraps to 0.
- MSB_FIRST=0, CHECKSUM_EN=0: STEP with 0xA1B2C3D4 → bytes D4,C3,B2,A1; no trailer.
- STOP mid-word: RUN, then 'S' arrives during byte 2 → byte 2 completes, no further bytes, IDLE, o_word_idx=0. Also 'S' during REQ → o_tx_ready drops next cycle.
- Busy filtering: 'R' and 'C' sent during a RUN are ignored, and the stream continues unchanged. 'C' in IDLE after two STEPs → o_word_idx=0.
